// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with registered result and iterative multi-cycle shifter
module alu_exec_unit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alu_ctrl,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic [4:0]  rd_out
);

    localparam logic [5:0] ADD_CTRL  = 6'b100000;
    localparam logic [5:0] SUB_CTRL  = 6'b100010;
    localparam logic [5:0] AND_CTRL  = 6'b100100;
    localparam logic [5:0] OR_CTRL   = 6'b100101;
    localparam logic [5:0] XOR_CTRL  = 6'b100110;
    localparam logic [5:0] SLT_CTRL  = 6'b101010;
    localparam logic [5:0] SLTU_CTRL = 6'b101011;
    localparam logic [5:0] SLL_CTRL  = 6'b000001;
    localparam logic [5:0] SRL_CTRL  = 6'b000010;
    localparam logic [5:0] SRA_CTRL  = 6'b000011;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] work, work_n;
    logic [4:0]  count, count_n;
    logic [5:0]  sh_op, sh_op_n;
    logic [4:0]  rd_q, rd_q_n;
    logic [31:0] result_n;
    logic        zero_n;
    logic [4:0]  rd_out_n;
    logic        out_valid_n;

    logic [31:0] alu_res;
    logic [31:0] shifted;
    logic [4:0]  step_k;
    logic [4:0]  shamt;
    logic        is_shift;
    logic        accept;

    assign shamt    = op_b[4:0];
    assign is_shift = (alu_ctrl == SLL_CTRL) || (alu_ctrl == SRL_CTRL) || (alu_ctrl == SRA_CTRL);
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign step_k   = (count < STEP_AMT) ? count : STEP_AMT;

    // Shift codes only reach this path with shamt==0, so they pass op_a through.
    always_comb begin
        alu_res = 32'd0;
        case (alu_ctrl)
            ADD_CTRL:  alu_res = op_a + op_b;
            SUB_CTRL:  alu_res = op_a - op_b;
            AND_CTRL:  alu_res = op_a & op_b;
            OR_CTRL:   alu_res = op_a | op_b;
            XOR_CTRL:  alu_res = op_a ^ op_b;
            SLT_CTRL:  alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            SLTU_CTRL: alu_res = (op_a < op_b) ? 32'd1 : 32'd0;
            SLL_CTRL,
            SRL_CTRL,
            SRA_CTRL:  alu_res = op_a;
            default:   alu_res = 32'd0;
        endcase
    end

    always_comb begin
        shifted = work;
        case (sh_op)
            SLL_CTRL: shifted = work << step_k;
            SRL_CTRL: shifted = work >> step_k;
            default:  shifted = $signed(work) >>> step_k;
        endcase
    end

    always_comb begin
        state_n     = state;
        work_n      = work;
        count_n     = count;
        sh_op_n     = sh_op;
        rd_q_n      = rd_q;
        result_n    = result;
        zero_n      = zero;
        rd_out_n    = rd_out;
        out_valid_n = out_valid;
        if (flush) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
            count_n     = 5'd0;
        end else if (state == SHIFT) begin
            work_n  = shifted;
            count_n = count - step_k;
            if (count == step_k) begin
                result_n    = shifted;
                zero_n      = (shifted == 32'd0);
                rd_out_n    = rd_q;
                out_valid_n = 1'b1;
                state_n     = HOLD;
            end
        end else begin
            if ((state == HOLD) && out_ready) begin
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
            // Accepting from HOLD reuses the IDLE path on the same edge.
            if (accept) begin
                if (is_shift && (shamt != 5'd0)) begin
                    work_n      = op_a;
                    count_n     = shamt;
                    sh_op_n     = alu_ctrl;
                    rd_q_n      = rd_in;
                    out_valid_n = 1'b0;
                    state_n     = SHIFT;
                end else begin
                    result_n    = alu_res;
                    zero_n      = (alu_res == 32'd0);
                    rd_out_n    = rd_in;
                    out_valid_n = 1'b1;
                    state_n     = HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= 32'd0;
            count     <= 5'd0;
            sh_op     <= 6'd0;
            rd_q      <= 5'd0;
            result    <= 32'd0;
            zero      <= 1'b0;
            rd_out    <= 5'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            work      <= work_n;
            count     <= count_n;
            sh_op     <= sh_op_n;
            rd_q      <= rd_q_n;
            result    <= result_n;
            zero      <= zero_n;
            rd_out    <= rd_out_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized model-based bench for alu_exec_unit (STEP=1 and STEP=4)
module tb_alu_exec_unit;

    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] ANDC = 6'b100100;
    localparam logic [5:0] ORC  = 6'b100101;
    localparam logic [5:0] XORC = 6'b100110;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] SLTU = 6'b101011;
    localparam logic [5:0] SLL  = 6'b000001;
    localparam logic [5:0] SRL  = 6'b000010;
    localparam logic [5:0] SRA  = 6'b000011;
    localparam int MSTEP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [5:0]  alu_ctrl;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        in_ready, out_valid, zero;
    logic [31:0] result;
    logic [4:0]  rd_out;

    logic        f_flush, f_in_valid, f_out_ready;
    logic [5:0]  f_alu_ctrl;
    logic [31:0] f_op_a, f_op_b;
    logic [4:0]  f_rd_in;
    logic        f_in_ready, f_out_valid, f_zero;
    logic [31:0] f_result;
    logic [4:0]  f_rd_out;

    always #5 clk = ~clk;

    alu_exec_unit #(.STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .rd_out(rd_out)
    );

    alu_exec_unit #(.STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .alu_ctrl(f_alu_ctrl), .op_a(f_op_a), .op_b(f_op_b), .rd_in(f_rd_in), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .result(f_result), .zero(f_zero), .rd_out(f_rd_out)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: results come from plain arithmetic, shifts only as a latency count.
    bit          m_valid;
    int          m_wait;
    logic [31:0] m_res, m_pend;
    logic [4:0]  m_rd, m_pend_rd;

    function automatic logic [31:0] ref_alu(logic [5:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            ADD:  return a + b;
            SUB:  return a - b;
            ANDC: return a & b;
            ORC:  return a | b;
            XORC: return a ^ b;
            SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            SLL:  return a << b[4:0];
            SRL:  return a >> b[4:0];
            SRA:  return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_wait = 0; m_res = 0; m_rd = 0; m_pend = 0; m_pend_rd = 0;
    endtask

    // Starts at a negedge, drives inputs, compares, crosses one rising edge, ends at the next negedge.
    task automatic cycle(bit iv, bit ordy, bit fl, logic [5:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        bit exp_rdy, acc;
        logic [31:0] r;
        int sh;
        in_valid = iv; out_ready = ordy; flush = fl; alu_ctrl = c; op_a = a; op_b = b; rd_in = rd;
        #1;
        exp_rdy = (m_wait == 0 && !m_valid) || (m_valid && ordy);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("result", result, m_res);
            check("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
            check("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
        end
        acc = iv && exp_rdy && !fl;
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1; m_res = m_pend; m_rd = m_pend_rd;
            end
        end else begin
            if (m_valid && ordy) m_valid = 0;
            if (acc) begin
                r  = ref_alu(c, a, b);
                sh = int'(b[4:0]);
                if ((c == SLL || c == SRL || c == SRA) && sh != 0) begin
                    m_wait = (sh + MSTEP - 1) / MSTEP;
                    m_pend = r; m_pend_rd = rd; m_valid = 0;
                end else begin
                    m_valid = 1; m_res = r; m_rd = rd;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(bit ordy);
        cycle(0, ordy, 0, 6'd0, 32'd0, 32'd0, 5'd0);
    endtask

    function automatic logic [5:0] rand_ctrl();
        logic [5:0] codes [10] = '{ADD, SUB, ANDC, ORC, XORC, SLT, SLTU, SLL, SRL, SRA};
        if ($urandom_range(0, 9) == 0) return 6'($urandom);
        return codes[$urandom_range(0, 9)];
    endfunction

    initial begin
        int n;
        logic [31:0] b;
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; alu_ctrl = 0; op_a = 0; op_b = 0; rd_in = 0;
        f_flush = 0; f_in_valid = 0; f_out_ready = 0; f_alu_ctrl = 0; f_op_a = 0; f_op_b = 0; f_rd_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        check("rst rd_out", {27'd0, rd_out}, 32'd0);
        rst_n = 1;
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        cycle(1, 1, 0, ADD, 32'd5, 32'd7, 5'd3);
        check("add lit", result, 32'd12);
        check("add zero lit", {31'd0, zero}, 32'd0);
        cycle(1, 1, 0, SUB, 32'd7, 32'd7, 5'd4);
        check("sub lit", result, 32'd0);
        check("sub zero lit", {31'd0, zero}, 32'd1);
        check("sub b2b valid", {31'd0, out_valid}, 32'd1);
        cycle(1, 1, 0, SLT, 32'hFFFFFFFF, 32'd1, 5'd5);
        check("slt lit", result, 32'd1);
        cycle(1, 1, 0, SLTU, 32'hFFFFFFFF, 32'd1, 5'd6);
        check("sltu lit", result, 32'd0);
        cycle(1, 1, 0, 6'd0, 32'h1234, 32'h5678, 5'd7);
        check("nop lit", result, 32'd0);
        check("nop zero lit", {31'd0, zero}, 32'd1);
        check("nop tag lit", {27'd0, rd_out}, 32'd7);
        idle(1);

        cycle(1, 0, 0, SRA, 32'h80000000, 32'd31, 5'd8);
        n = 0;
        while (!out_valid && n < 100) begin idle(0); n++; end
        check("sra31 latency", n, 32'd31);
        check("sra31 lit", result, 32'hFFFFFFFF);
        idle(1);

        cycle(1, 1, 0, SRL, 32'hDEADBEEF, 32'h20, 5'd9);
        check("srl0 lit", result, 32'hDEADBEEF);
        cycle(1, 1, 0, SLL, 32'd1, 32'd4, 5'd10);
        n = 0;
        while (!out_valid && n < 100) begin idle(0); n++; end
        check("sll4 latency", n, 32'd4);
        check("sll4 lit", result, 32'd16);

        repeat (3) cycle(1, 0, 0, ADD, 32'd100, 32'd1, 5'd11);
        check("hold result lit", result, 32'd16);
        check("hold tag lit", {27'd0, rd_out}, 32'd10);
        cycle(1, 1, 0, XORC, 32'hF0F0, 32'h0FF0, 5'd12);
        check("hold accept lit", result, 32'hFF00);
        idle(1);

        cycle(1, 1, 0, SRA, 32'h40000000, 32'd31, 5'd13);
        repeat (9) idle(1);
        cycle(1, 1, 1, ADD, 32'd1, 32'd1, 5'd14);
        check("flush valid lit", {31'd0, out_valid}, 32'd0);
        #1 check("flush ready lit", {31'd0, in_ready}, 32'd1);
        repeat (40) idle(1);

        cycle(1, 1, 0, ADD, 32'd1, 32'd2, 5'd15);
        cycle(1, 1, 0, SLL, 32'hFFFFFFFF, 32'd20, 5'd16);
        repeat (5) idle(1);
        check("pre-reset result", result, 32'd3);
        #2 rst_n = 0;
        #1;
        check("async rst valid", {31'd0, out_valid}, 32'd0);
        check("async rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  rand_ctrl(), ($urandom_range(0, 7) == 0) ? b : $urandom, b, 5'($urandom));
        end

        f_in_valid = 1; f_out_ready = 0; f_alu_ctrl = SRA; f_op_a = 32'h80000000; f_op_b = 32'd31; f_rd_in = 5'd2;
        #1 check("s4 ready", {31'd0, f_in_ready}, 32'd1);
        @(negedge clk);
        f_in_valid = 0;
        n = 0;
        while (!f_out_valid && n < 100) begin
            check("s4 busy ready", {31'd0, f_in_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("s4 sra31 latency", n, 32'd8);
        check("s4 sra31 lit", f_result, 32'hFFFFFFFF);
        check("s4 tag lit", {27'd0, f_rd_out}, 32'd2);
        f_out_ready = 1; f_in_valid = 1; f_alu_ctrl = SLL; f_op_a = 32'h3; f_op_b = 32'd5;
        @(negedge clk);
        f_in_valid = 0;
        n = 0;
        while (!f_out_valid && n < 100) begin @(negedge clk); n++; end
        check("s4 sll5 latency", n, 32'd2);
        check("s4 sll5 lit", f_result, 32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 6-bit ALU control code from the ALU control unit, plus two 32-bit operands and a destination tag.
- Produces a registered result, a zero flag and the tag for the writeback/branch logic.
- Logic/arithmetic/compare ops complete in one cycle. Shifts use an iterative multi-cycle shifter.
- Valid/ready handshakes on input and output; synchronous flush.

Parameters:
- STEP, 1, bits shifted per cycle in the iterative shifter. Legal values: 1, 2, 4, 8.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of in-flight op
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept this cycle
- alu_ctrl  input  6  ALU control code (Parameters.vh encodings)
- op_a  input  32  operand A (rs1)
- op_b  input  32  operand B (rs2 or immediate); shamt = op_b[4:0]
- rd_in  input  5  destination register tag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  32  registered ALU result
- zero  output  1  result == 0
- rd_out  output  5  tag of the result

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, rd_out=0, internal shift count=0.
- Codes used: add_ctrl, sub_ctrl, and_ctrl, or_ctrl, xor_ctrl, slt_ctrl, sltu_ctrl, sll_ctrl, srl_ctrl, sra_ctrl from Parameters.vh. All are nonzero.
- 6'b000000 and any unlisted code mean NOP: result=0, zero=1, latency 1, tag passed through.
- Acceptance occurs on a rising edge where in_valid && in_ready && !flush.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is a combinational path from out_ready and allows back-to-back ops.
- Operands, alu_ctrl and rd_in are captured at acceptance. Input changes after acceptance are ignored.
- State IDLE:
  - Accepting a non-shift op, or a shift with shamt==0: compute and register result, out_valid=1, go to HOLD. Latency 1 edge.
  - Accepting a shift with shamt>0: load working reg=op_a, count=shamt, go to SHIFT.
- State SHIFT:
  - Each edge shifts the working reg by k=min(STEP,count) and sets count -= k.
  - sll fills with zeros, srl fills with zeros, sra fills with working reg bit 31.
  - On the edge where count becomes 0: result=working value, out_valid=1, go to HOLD.
  - Total latency = ceil(shamt/STEP) edges after acceptance. Example: shamt=31, STEP=1 gives 31.
  - in_ready=0 throughout SHIFT.
- State HOLD:
  - result, zero and rd_out are held stable while out_ready=0.
  - On out_ready=1 with no new acceptance: out_valid=0, go to IDLE.
  - On out_ready=1 with a simultaneous acceptance: processed as an IDLE acceptance on the same edge, with no bubble.
- Arithmetic:
  - add/sub are modulo 2^32; no overflow flag.
  - slt is a signed compare; sltu is an unsigned compare. Result is 32'd1 or 32'd0.
  - Shift amount uses op_b[4:0] only; op_b[31:5] is ignored.
- zero is registered together with result and always equals (result==0).
- Flush (synchronous): has priority over everything.
  - Next state is IDLE, out_valid=0, count=0.
  - An in-flight shift or held result is discarded. No acceptance occurs that cycle even if in_valid && in_ready.
  - result, zero and rd_out may keep stale values.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). After deassertion the block is in IDLE with in_ready=1.

Test Plan:
- add_ctrl, a=5, b=7, out_ready=1 -> one edge later: out_valid=1, result=12, zero=0. Then sub_ctrl, a=7, b=7 back-to-back -> result=0, zero=1, no idle cycle between.
- slt_ctrl, a=32'hFFFFFFFF, b=1 -> result=1. sltu_ctrl with the same operands -> result=0. alu_ctrl=0 -> result=0, zero=1.
- STEP=1, sra_ctrl, a=32'h80000000, b=31 -> out_valid exactly 31 edges after acceptance, result=32'hFFFFFFFF, in_ready=0 throughout. Repeat with STEP=4 -> 8 edges.
- srl_ctrl, a=32'hDEADBEEF, b=32'h20 (shamt=0) -> 1 edge, result=32'hDEADBEEF. sll_ctrl, a=1, b=4 -> result=16.
- Hold out_ready=0 for 3 cycles after a result -> result, zero, rd_out and out_valid stay stable and in_ready=0. Then out_ready=1 together with a new in_valid -> new op accepted on that edge.
- Assert flush on the 10th cycle of a 31-bit shift -> next cycle state is IDLE, out_valid=0, in_ready=1, and the old result never appears. Separately, pull rst_n low mid-shift -> out_valid=0 and result=0 without a clock edge.
